// File: rtl/reorder_pkg.sv
// ============================================================================
// Module      : reorder_pkg
// Description : Shared store-entry type and big-endian lane constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reorder_pkg;

  localparam int ENTRY_AW = 30;

  // Big-endian lanes: byte offset 0 lives in data[31:24] / byte_en[3].
  localparam int LANE0 = 3;
  localparam int LANE1 = 2;
  localparam int LANE2 = 1;
  localparam int LANE3 = 0;

  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic [ENTRY_AW-1:0] addr;
    logic [3:0]          byte_en;
    logic [31:0]         data;
  } store_entry_t;

endpackage

`default_nettype wire

// File: rtl/store_fwd_merge.sv
// ============================================================================
// Module      : store_fwd_merge
// Description : Per-lane store-to-load forwarding, youngest matching entry wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_fwd_merge
  import reorder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  store_entry_t                 entries_i [DEPTH],
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [$clog2(DEPTH)-1:0]     tail_i,
  input  logic [AW-1:0]                ld_addr_i,
  output logic [3:0]                   fwd_mask_o,
  output logic [31:0]                  fwd_data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]       idx;
  logic [ENTRY_AW-1:0] ld_addr_ext;

  assign ld_addr_ext = ENTRY_AW'(ld_addr_i);

  // Walk slots oldest-to-youngest starting at tail, so later matches overwrite.
  always_comb begin
    fwd_mask_o = '0;
    fwd_data_o = '0;
    idx        = tail_i;
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail_i + PW'(k);
      if (valid_i[idx] && (entries_i[idx].addr == ld_addr_ext)) begin
        for (int b = 0; b < 4; b++) begin
          if (entries_i[idx].byte_en[b]) begin
            fwd_mask_o[b]         = 1'b1;
            fwd_data_o[8*b +: 8]  = entries_i[idx].data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module      : store_buffer
// Description : In-order posted-write buffer with per-byte load forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer
  import reorder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       st_valid_i,
  output logic                       st_ready_o,
  input  logic [AW-1:0]              st_addr_i,
  input  logic [3:0]                 st_byte_en_i,
  input  logic [31:0]                st_data_i,
  output logic                       mem_valid_o,
  input  logic                       mem_ready_i,
  output logic [AW-1:0]              mem_addr_o,
  output logic [3:0]                 mem_byte_en_o,
  output logic [31:0]                mem_data_o,
  input  logic [AW-1:0]              ld_addr_i,
  output logic [3:0]                 fwd_mask_o,
  output logic [31:0]                fwd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  store_entry_t     entries_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign st_ready_o  = (count_q < CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign mem_valid_o = !empty_o;
  assign count_o     = count_q;

  // A zero-enable store completes its handshake but occupies no slot.
  assign push = st_valid_i && st_ready_o && (st_byte_en_i != 4'b0000);
  assign pop  = mem_valid_o && mem_ready_i;

  assign mem_addr_o    = AW'(entries_q[head_q].addr);
  assign mem_byte_en_o = entries_q[head_q].byte_en;
  assign mem_data_o    = entries_q[head_q].data;

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by valid_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      entries_q[tail_q].addr    <= ENTRY_AW'(st_addr_i);
      entries_q[tail_q].byte_en <= st_byte_en_i;
      entries_q[tail_q].data    <= st_data_i;
    end
  end

  store_fwd_merge #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fwd_merge (
    .entries_i  (entries_q),
    .valid_i    (valid_q),
    .tail_i     (tail_q),
    .ld_addr_i  (ld_addr_i),
    .fwd_mask_o (fwd_mask_o),
    .fwd_data_o (fwd_data_o)
  );

endmodule

`default_nettype wire
